// File: rtl/pipe_stage_reg_pkg.sv
// Shared encodings for the generalised inter-stage pipeline register.
package pipe_stage_reg_pkg;

   // Legacy core encodings carried over from the fixed-field stage registers
   localparam logic        STOP              = 1'b1;
   localparam logic        NO_STOP           = 1'b0;
   localparam logic        RST_ENABLE        = 1'b1;
   localparam logic        NOT_IN_DELAY_SLOT = 1'b0;
   localparam logic [31:0] ZERO_WORD         = 32'h0000_0000;

   // One action per cycle, listed in priority order
   typedef enum logic [2:0] {
      ACT_RST    = 3'd0,
      ACT_FLUSH  = 3'd1,
      ACT_BUBBLE = 3'd2,
      ACT_ADV    = 3'd3,
      ACT_HOLD   = 3'd4
   } stage_act_e;

   // Resolve reset/flush/stall into the single action taken this cycle.
   // s_up=0 always advances, including the illegal s_up=0/s_dn=1 pattern.
   function automatic stage_act_e decode_act(input logic rst, input logic flush,
                                             input logic s_up, input logic s_dn);
      if (rst == RST_ENABLE)              return ACT_RST;
      else if (flush)                     return ACT_FLUSH;
      else if (s_up == NO_STOP)           return ACT_ADV;
      else if (s_dn == NO_STOP)           return ACT_BUBBLE;
      else                                return ACT_HOLD;
   endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter; clear overrides increment, reset overrides clear.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] q
);

   logic [CNT_W-1:0] r_q;

   // Count up on inc, sticking at all-ones instead of wrapping
   always_ff @(posedge clk) begin
      if (rst)                       r_q <= '0;
      else if (clr)                  r_q <= '0;
      else if (inc && (r_q != '1))   r_q <= r_q + CNT_W'(1);
   end

   assign q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with stall/bubble/flush
// handling, delay-slot token tracking and saturating perf counters.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int                DATA_W    = 128,
   parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
   parameter int                STALL_W   = 6,
   parameter int                STAGE     = 2,
   parameter int                CNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic [DATA_W-1:0]  in_data,
   input  logic               in_valid,
   input  logic               in_is_in_delayslot,
   input  logic               next_inst_delayslot_i,
   input  logic               cnt_clr,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_valid,
   output logic               out_is_in_delayslot,
   output logic               ds_token_o,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   bubble_cnt,
   output logic [CNT_W-1:0]   flush_cnt
);

   // STAGE+1 must still index the stall vector
   if (STAGE > STALL_W-2) begin : g_bad_stage
      $fatal(1, "pipe_stage_reg: STAGE out of range 0..STALL_W-2");
   end

   logic              w_s_up;
   logic              w_s_dn;
   stage_act_e        w_act;
   logic [DATA_W-1:0] r_data;
   logic              r_valid;
   logic              r_ds;
   logic              r_ds_token;

   assign w_s_up = stall[STAGE];
   assign w_s_dn = stall[STAGE+1];
   assign w_act  = decode_act(rst, flush, w_s_up, w_s_dn);

   // Payload and flags: load on advance, NOP on reset/flush/bubble, keep on hold
   always_ff @(posedge clk) begin
      case (w_act)
         ACT_RST, ACT_FLUSH: begin
            r_data     <= NOP_VALUE;
            r_valid    <= 1'b0;
            r_ds       <= NOT_IN_DELAY_SLOT;
            r_ds_token <= 1'b0;
         end
         ACT_BUBBLE: begin
            // token is kept so the branch's delay slot still gets marked
            r_data     <= NOP_VALUE;
            r_valid    <= 1'b0;
            r_ds       <= NOT_IN_DELAY_SLOT;
         end
         ACT_ADV: begin
            r_data     <= in_data;
            r_valid    <= in_valid;
            r_ds       <= in_is_in_delayslot & in_valid;
            r_ds_token <= next_inst_delayslot_i & in_valid;
         end
         default: ;
      endcase
   end

   assign out_data            = r_data;
   assign out_valid           = r_valid;
   assign out_is_in_delayslot = r_ds;
   assign ds_token_o          = r_ds_token;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk (clk), .rst (rst), .inc (w_act == ACT_HOLD),
      .clr (cnt_clr), .q (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk (clk), .rst (rst), .inc (w_act == ACT_BUBBLE),
      .clr (cnt_clr), .q (bubble_cnt)
   );

   // Only flushes that actually kill a live instruction are counted
   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk (clk), .rst (rst), .inc ((w_act == ACT_FLUSH) && r_valid),
      .clr (cnt_clr), .q (flush_cnt)
   );

`ifndef SYNTHESIS
   // Flag the illegal stall pattern: downstream stopped while upstream runs
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(w_s_dn == STOP && w_s_up == NO_STOP))
            else $error("pipe_stage_reg: illegal stall pattern %b", stall);
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed test of pipe_stage_reg: reset, advance, bubble, hold, flush,
// counter clear and saturation, reset during hold.
module tb_pipe_stage_reg;

   localparam int          DW  = 32;
   localparam logic [31:0] NOP = 32'hA5A5_0000;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, in_ds, next_ds, cnt_clr;
   logic [5:0]    stall;
   logic [DW-1:0] in_data;

   logic [DW-1:0] out_data, out_data4;
   logic          out_valid, out_ds, ds_tok, out_valid4, out_ds4, ds_tok4;
   logic [15:0]   stall_cnt, bubble_cnt, flush_cnt;
   logic [3:0]    stall_cnt4, bubble_cnt4, flush_cnt4;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(DW), .NOP_VALUE(NOP), .STALL_W(6), .STAGE(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_data(in_data),
      .in_valid(in_valid), .in_is_in_delayslot(in_ds), .next_inst_delayslot_i(next_ds),
      .cnt_clr(cnt_clr), .out_data(out_data), .out_valid(out_valid),
      .out_is_in_delayslot(out_ds), .ds_token_o(ds_tok), .stall_cnt(stall_cnt),
      .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
   );

   pipe_stage_reg #(.DATA_W(DW), .NOP_VALUE(NOP), .STALL_W(6), .STAGE(2), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_data(in_data),
      .in_valid(in_valid), .in_is_in_delayslot(in_ds), .next_inst_delayslot_i(next_ds),
      .cnt_clr(cnt_clr), .out_data(out_data4), .out_valid(out_valid4),
      .out_is_in_delayslot(out_ds4), .ds_token_o(ds_tok4), .stall_cnt(stall_cnt4),
      .bubble_cnt(bubble_cnt4), .flush_cnt(flush_cnt4)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_out(input string tag, input logic [31:0] d, input logic v,
                          input logic ds, input logic tok);
      chk({tag, ".data"},  out_data, d);
      chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
      chk({tag, ".ds"},    {31'd0, out_ds},    {31'd0, ds});
      chk({tag, ".tok"},   {31'd0, ds_tok},    {31'd0, tok});
   endtask

   task automatic chk_cnt(input string tag, input int s, input int b, input int f);
      chk({tag, ".stall_cnt"},  {16'd0, stall_cnt},  s);
      chk({tag, ".bubble_cnt"}, {16'd0, bubble_cnt}, b);
      chk({tag, ".flush_cnt"},  {16'd0, flush_cnt},  f);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; cnt_clr = 1'b0; stall = 6'b000000;
      in_data = 32'hDEAD_BEEF; in_valid = 1'b1; in_ds = 1'b1; next_ds = 1'b1;
      step(2);
      chk_out("reset", NOP, 1'b0, 1'b0, 1'b0);
      chk_cnt("reset", 0, 0, 0);

      // advance a real instruction that flags the next one as delay slot
      rst = 1'b0; in_data = 32'h0000_1234; in_valid = 1'b1; in_ds = 1'b1; next_ds = 1'b1;
      step(1);
      chk_out("adv", 32'h0000_1234, 1'b1, 1'b1, 1'b1);

      // bubble x3: NOP out, token survives
      stall = 6'b000111; in_data = 32'h0000_5555;
      step(3);
      chk_out("bubble", NOP, 1'b0, 1'b0, 1'b1);
      chk_cnt("bubble", 0, 3, 0);

      // hold x4 after bubble: frozen
      stall = 6'b001111;
      step(4);
      chk_out("hold_nop", NOP, 1'b0, 1'b0, 1'b1);
      chk_cnt("hold_nop", 4, 3, 0);

      // advance then hold a live instruction while input changes
      stall = 6'b000000; in_data = 32'h0000_ABCD; in_ds = 1'b1; next_ds = 1'b0;
      step(1);
      chk_out("adv2", 32'h0000_ABCD, 1'b1, 1'b1, 1'b0);
      stall = 6'b001111; in_data = 32'h0000_9999; in_ds = 1'b0; next_ds = 1'b1;
      step(2);
      chk_out("hold_live", 32'h0000_ABCD, 1'b1, 1'b1, 1'b0);
      chk_cnt("hold_live", 6, 3, 0);

      // flush beats hold; counts because out_valid was 1
      flush = 1'b1;
      step(1);
      chk_out("flush1", NOP, 1'b0, 1'b0, 1'b0);
      chk_cnt("flush1", 6, 3, 1);
      // second flush with out_valid=0 is not counted
      step(1);
      chk_cnt("flush2", 6, 3, 1);

      // advance an invalid slot: flags gated by in_valid
      flush = 1'b0; stall = 6'b000000; in_data = 32'h0000_7777;
      in_valid = 1'b0; in_ds = 1'b1; next_ds = 1'b1;
      step(1);
      chk_out("adv_inv", 32'h0000_7777, 1'b0, 1'b0, 1'b0);

      // flush of a live instruction together with cnt_clr: clear wins
      in_data = 32'h0000_1111; in_valid = 1'b1; in_ds = 1'b0; next_ds = 1'b1;
      step(1);
      chk_out("adv3", 32'h0000_1111, 1'b1, 1'b0, 1'b1);
      flush = 1'b1; cnt_clr = 1'b1;
      step(1);
      chk_out("flush_clr", NOP, 1'b0, 1'b0, 1'b0);
      chk_cnt("flush_clr", 0, 0, 0);

      // 20 hold cycles: 16-bit counts on, 4-bit saturates at 15
      flush = 1'b0; cnt_clr = 1'b0; stall = 6'b001111;
      step(20);
      chk("sat.stall_cnt16", {16'd0, stall_cnt}, 20);
      chk("sat.stall_cnt4", {28'd0, stall_cnt4}, 15);
      cnt_clr = 1'b1;
      step(1);
      chk("clr.stall_cnt16", {16'd0, stall_cnt}, 0);
      chk("clr.stall_cnt4", {28'd0, stall_cnt4}, 0);

      // reset in the middle of holding a live instruction
      cnt_clr = 1'b0; stall = 6'b000000; in_data = 32'h0000_2222; in_valid = 1'b1;
      step(1);
      stall = 6'b001111;
      step(1);
      chk_out("hold_pre_rst", 32'h0000_2222, 1'b1, 1'b0, 1'b1);
      chk("hold_pre_rst.stall_cnt", {16'd0, stall_cnt}, 1);
      rst = 1'b1; flush = 1'b1;
      step(1);
      chk_out("rst_mid", NOP, 1'b0, 1'b0, 1'b0);
      chk_cnt("rst_mid", 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
